// File: rtl/vga_overlay_pkg.sv
// Shared constants and geometry helper for the seven-segment / cursor
// overlay stage.
//   SEG_A..SEG_G : bit positions of the segments inside a 7-bit enable field
//   BGR_*        : field slices of a packed 24-bit BGR pixel
//   BTN_*        : bit positions inside the packed button vector
//   segHits()    : per-segment hit mask for a pixel at (dx, dy) relative
//                  to a digit origin
package vga_overlay_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int BGR_B_MSB = 23;
    localparam int BGR_B_LSB = 16;
    localparam int BGR_G_MSB = 15;
    localparam int BGR_G_LSB = 8;
    localparam int BGR_R_MSB = 7;
    localparam int BGR_R_LSB = 0;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    function automatic logic inRange(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Bounds are inclusive. Negative dx/dy (pixel left of / above the
    // origin) never hits because every lower bound is >= 0.
    function automatic logic [6:0] segHits(input int dx, input int dy,
                                           input int l, input int s, input int g);
        int t;
        logic [6:0] h;
        t = s + g;
        h = '0;
        h[SEG_A] = inRange(dy, 0, s)                         && inRange(dx, 0, l + g + s);
        h[SEG_B] = inRange(dy, t, t + l)                     && inRange(dx, l + g, l + g + s);
        h[SEG_C] = inRange(dy, t + g + l, t + g + 2*l)       && inRange(dx, l + g, l + g + s);
        h[SEG_D] = inRange(dy, t + 2*g + 2*l, 2*s + 3*g + 2*l) && inRange(dx, 0, l + g + s);
        h[SEG_E] = inRange(dy, t + g + l, t + g + 2*l)       && inRange(dx, 0, s);
        h[SEG_F] = inRange(dy, t, t + l)                     && inRange(dx, 0, s);
        h[SEG_G] = inRange(dy, t + l, t + l + s)             && inRange(dx, t, l);
        return h;
    endfunction

endpackage

// File: rtl/seg_digit_hit.sv
// Combinational hit test for one seven-segment digit.
//   iX, iY   : current pixel position
//   iSegN    : segment enables, active-low, bit 0..6 = a..g
//   oHit     : pixel lies on an enabled segment of this digit
module seg_digit_hit
    import vga_overlay_pkg::*;
#(
    parameter int ORG_X = 100,
    parameter int ORG_Y = 15,
    parameter int SEG_L = 60,
    parameter int SEG_S = 6,
    parameter int SEG_G = 3
) (
    input  logic [9:0] iX,
    input  logic [8:0] iY,
    input  logic [6:0] iSegN,
    output logic       oHit
);

    logic [6:0] hits;

    always_comb begin
        hits = segHits(int'(iX) - ORG_X, int'(iY) - ORG_Y, SEG_L, SEG_S, SEG_G);
        oHit = |(hits & ~iSegN);
    end

endmodule

// File: rtl/vga_seg_overlay.sv
// Overlay stage between the palette lookup and the VGA DAC: draws
// NUM_DIGITS seven-segment digits and a button-driven square cursor over
// the background pixel stream, with one register stage of latency.
// Optional build macro SEG_BLINK_EN adds iBLINK and a frame counter that
// blanks flagged digits for 32 of every 64 frames.
//   iVGA_CLK, iRST_n            : pixel clock, async active-low reset
//   iBLANK_n, iHS, iVS, iBGR    : incoming video, syncs active-low
//   iSEG                        : 7 active-low segment enables per digit
//   iBLINK (SEG_BLINK_EN only)  : per-digit blink enable
//   mLeft/mRight/mUp/mDown      : async active-low buttons
//   oBLANK_n, oHS, oVS          : syncs delayed one cycle
//   b_data, g_data, r_data      : output colour
//   oCUR_X, oCUR_Y              : cursor top-left position
module vga_seg_overlay
    import vga_overlay_pkg::*;
#(
    parameter int          H_ACT      = 640,
    parameter int          V_ACT      = 480,
    parameter int          NUM_DIGITS = 4,
    parameter int          DIG_X0     = 100,
    parameter int          DIG_Y0     = 15,
    parameter int          DIG_PITCH  = 90,
    parameter int          SEG_L      = 60,
    parameter int          SEG_S      = 6,
    parameter int          SEG_G      = 3,
    parameter logic [23:0] SEG_BGR    = 24'h000000,
    parameter int          CUR_SIZE   = 50,
    parameter int          CUR_X0     = 40,
    parameter int          CUR_Y0     = 1,
    parameter int          CUR_STEP   = 2,
    parameter logic [23:0] CUR_BGR    = 24'h00FF00
) (
    input  logic                    iVGA_CLK,
    input  logic                    iRST_n,
    input  logic                    iBLANK_n,
    input  logic                    iHS,
    input  logic                    iVS,
    input  logic [23:0]             iBGR,
    input  logic [7*NUM_DIGITS-1:0] iSEG,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   iBLINK,
`endif
    input  logic                    mLeft,
    input  logic                    mRight,
    input  logic                    mUp,
    input  logic                    mDown,
    output logic                    oBLANK_n,
    output logic                    oHS,
    output logic                    oVS,
    output logic [7:0]              b_data,
    output logic [7:0]              g_data,
    output logic [7:0]              r_data,
    output logic [9:0]              oCUR_X,
    output logic [8:0]              oCUR_Y
);

    logic [9:0] x;
    logic [8:0] y;
    logic       blankPrev;
    logic       vsPrev;
    logic       vsFall;
    logic       aligned;
    logic [3:0] btnMeta;
    logic [3:0] btnSync;
    logic [3:0] pressed;
    logic [9:0] curX;
    logic [8:0] curY;
    logic signed [10:0] stepX, stepY, nextX, nextY;
    logic [10:0] curXEnd;
    logic [9:0]  curYEnd;
    logic        curHit;
    logic [NUM_DIGITS-1:0] digHit;
    logic [NUM_DIGITS-1:0] digEn;
    logic        segAny;
    logic        vld_p0;
    logic [23:0] colour_p0;

    function automatic logic [9:0] satX(input logic signed [10:0] v);
        if (v < 11'sd0)
            return '0;
        if (v > 11'(H_ACT - CUR_SIZE))
            return 10'(H_ACT - CUR_SIZE);
        return v[9:0];
    endfunction

    function automatic logic [8:0] satY(input logic signed [10:0] v);
        if (v < 11'sd0)
            return '0;
        if (v > 11'(V_ACT - CUR_SIZE))
            return 9'(V_ACT - CUR_SIZE);
        return v[8:0];
    endfunction

    assign vsFall = vsPrev & ~iVS;

    // Position counters. 'aligned' stays low after a reset until a vsync
    // has re-zeroed y, so a mid-frame reset never draws at wrong rows.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x         <= '0;
            y         <= '0;
            blankPrev <= 1'b0;
            vsPrev    <= 1'b1;
            aligned   <= 1'b0;
        end else begin
            blankPrev <= iBLANK_n;
            vsPrev    <= iVS;
            if (!iVS) begin
                x       <= '0;
                y       <= '0;
                aligned <= 1'b1;
            end else begin
                x <= iBLANK_n ? x + 10'd1 : '0;
                if (blankPrev && !iBLANK_n)
                    y <= y + 9'd1;
            end
        end
    end

    // Two-flop synchroniser; released buttons read as 1.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            btnMeta <= '1;
            btnSync <= '1;
        end else begin
            btnMeta <= {mDown, mUp, mRight, mLeft};
            btnSync <= btnMeta;
        end
    end

    assign pressed = ~btnSync;

    // Opposing buttons cancel.
    always_comb begin
        stepX = '0;
        stepY = '0;
        if (pressed[BTN_RIGHT] && !pressed[BTN_LEFT])
            stepX = 11'(CUR_STEP);
        else if (pressed[BTN_LEFT] && !pressed[BTN_RIGHT])
            stepX = 11'(-CUR_STEP);
        if (pressed[BTN_DOWN] && !pressed[BTN_UP])
            stepY = 11'(CUR_STEP);
        else if (pressed[BTN_UP] && !pressed[BTN_DOWN])
            stepY = 11'(-CUR_STEP);
        nextX = $signed({1'b0, curX}) + stepX;
        nextY = $signed({2'b00, curY}) + stepY;
    end

    // Cursor moves only on the first vsync-low cycle of each frame.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            curX <= 10'(CUR_X0);
            curY <= 9'(CUR_Y0);
        end else if (vsFall) begin
            curX <= satX(nextX);
            curY <= satY(nextY);
        end
    end

    assign oCUR_X = curX;
    assign oCUR_Y = curY;

`ifdef SEG_BLINK_EN
    logic [7:0] frameCnt;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            frameCnt <= '0;
        else if (vsFall)
            frameCnt <= frameCnt + 8'd1;
    end

    assign digEn = ~(iBLINK & {NUM_DIGITS{frameCnt[5]}});
`else
    assign digEn = '1;
`endif

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
        seg_digit_hit #(
            .ORG_X (DIG_X0 + i*DIG_PITCH),
            .ORG_Y (DIG_Y0),
            .SEG_L (SEG_L),
            .SEG_S (SEG_S),
            .SEG_G (SEG_G)
        ) uHit (
            .iX    (x),
            .iY    (y),
            .iSegN (iSEG[7*i +: 7]),
            .oHit  (digHit[i])
        );
    end

    // All digits share one colour, so OR-ing the hits is equivalent to
    // letting the lowest index win.
    always_comb begin
        curXEnd   = {1'b0, curX} + 11'(CUR_SIZE - 1);
        curYEnd   = {1'b0, curY} + 10'(CUR_SIZE - 1);
        curHit    = (x >= curX) && ({1'b0, x} <= curXEnd) &&
                    (y >= curY) && ({1'b0, y} <= curYEnd);
        segAny    = |(digHit & digEn);
        vld_p0    = iBLANK_n & aligned;
        colour_p0 = iBGR;
        if (segAny)
            colour_p0 = SEG_BGR;
        if (curHit)
            colour_p0 = CUR_BGR;
        if (!vld_p0)
            colour_p0 = '0;
    end

    // ---- stage p0 -> output register ----
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oBLANK_n <= 1'b0;
            oHS      <= 1'b1;
            oVS      <= 1'b1;
            b_data   <= '0;
            g_data   <= '0;
            r_data   <= '0;
        end else begin
            oBLANK_n <= iBLANK_n;
            oHS      <= iHS;
            oVS      <= iVS;
            b_data   <= colour_p0[BGR_B_MSB:BGR_B_LSB];
            g_data   <= colour_p0[BGR_G_MSB:BGR_G_LSB];
            r_data   <= colour_p0[BGR_R_MSB:BGR_R_LSB];
        end
    end

endmodule

// File: tb/tb_vga_seg_overlay.sv
// Bench for vga_seg_overlay with default parameters. Short synthetic frames
// are driven; every output cycle is compared with a rectangle-based model
// of the overlay and a per-frame model of the cursor position.
module tb_vga_seg_overlay;

    logic        clk = 1'b0;
    logic        iRST_n;
    logic        iBLANK_n, iHS, iVS;
    logic [23:0] iBGR;
    logic [27:0] iSEG;
    logic [3:0]  iBLINK;
    logic        mLeft, mRight, mUp, mDown;
    logic        oBLANK_n, oHS, oVS;
    logic [7:0]  b_data, g_data, r_data;
    logic [9:0]  oCUR_X;
    logic [8:0]  oCUR_Y;

    always #5 clk = ~clk;

    vga_seg_overlay dut (
        .iVGA_CLK (clk),
        .iRST_n   (iRST_n),
        .iBLANK_n (iBLANK_n),
        .iHS      (iHS),
        .iVS      (iVS),
        .iBGR     (iBGR),
        .iSEG     (iSEG),
`ifdef SEG_BLINK_EN
        .iBLINK   (iBLINK),
`endif
        .mLeft    (mLeft),
        .mRight   (mRight),
        .mUp      (mUp),
        .mDown    (mDown),
        .oBLANK_n (oBLANK_n),
        .oHS      (oHS),
        .oVS      (oVS),
        .b_data   (b_data),
        .g_data   (g_data),
        .r_data   (r_data),
        .oCUR_X   (oCUR_X),
        .oCUR_Y   (oCUR_Y)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int mCx, mCy, mFrame;
    bit mAligned;
    bit pL, pR, pU, pD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] outCol();
        return {b_data, g_data, r_data};
    endfunction

    function automatic bit inR(input int v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction

    // Segment rectangles for L=60, S=6, G=3 (T=9), relative to a digit origin.
    function automatic bit segRect(input int s, input int dx, input int dy);
        case (s)
            0: return inR(dy, 0, 6)     && inR(dx, 0, 69);
            1: return inR(dy, 9, 69)    && inR(dx, 63, 69);
            2: return inR(dy, 72, 132)  && inR(dx, 63, 69);
            3: return inR(dy, 135, 141) && inR(dx, 0, 69);
            4: return inR(dy, 72, 132)  && inR(dx, 0, 6);
            5: return inR(dy, 9, 69)    && inR(dx, 0, 6);
            6: return inR(dy, 69, 75)   && inR(dx, 9, 60);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] expPix(input int px, input int py, input logic [23:0] bg);
        if (!mAligned)
            return 24'h0;
        if (px >= mCx && px < mCx + 50 && py >= mCy && py < mCy + 50)
            return 24'h00FF00;
        for (int d = 0; d < 4; d++) begin
`ifdef SEG_BLINK_EN
            if (iBLINK[d] && ((mFrame / 32) % 2 == 1))
                continue;
`endif
            for (int s = 0; s < 7; s++)
                if (!iSEG[7*d + s] && segRect(s, px - (100 + 90*d), py - 15))
                    return 24'h000000;
        end
        return bg;
    endfunction

    function automatic int clampI(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic vsyncModel();
        int dx, dy;
        dx = (pR && !pL) ? 2 : (pL && !pR) ? -2 : 0;
        dy = (pD && !pU) ? 2 : (pU && !pD) ? -2 : 0;
        mCx = clampI(mCx + dx, 640 - 50);
        mCy = clampI(mCy + dy, 480 - 50);
        mFrame++;
        mAligned = 1'b1;
    endtask

    task automatic setButtons();
        mLeft = ~pL; mRight = ~pR; mUp = ~pU; mDown = ~pD;
    endtask

    task automatic step(input logic blank, input logic hs, input logic vs,
                        input logic [23:0] bg, input logic [23:0] expCol, input string tag);
        iBLANK_n = blank; iHS = hs; iVS = vs; iBGR = bg;
        @(posedge clk); #1;
        check({tag, "_rgb"}, {8'h0, outCol()}, {8'h0, expCol});
        check({tag, "_sync"}, {29'h0, oBLANK_n, oHS, oVS}, {29'h0, blank, hs, vs});
    endtask

    task automatic frame(input int nLines, input int width, input bit rndPix, input int spot);
        logic [23:0] bg;
        repeat (4) step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "idle");
        vsyncModel();
        repeat (2) step(1'b0, 1'b1, 1'b0, 24'($urandom), 24'h0, "vsync");
        repeat (2) step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "bporch");
        for (int ly = 0; ly < nLines; ly++) begin
            for (int px = 0; px < width; px++) begin
                bg = rndPix ? 24'($urandom) : 24'h123456;
                step(1'b1, 1'b1, 1'b1, bg, expPix(px, ly, bg), "pix");
                if (spot == 1) begin
                    if (px == 0   && ly == 0)  check("first_pix_bg", {8'h0, outCol()}, 32'h123456);
                    if (px == 40  && ly == 1)  check("cursor_40_1",  {8'h0, outCol()}, 32'h00FF00);
                    if (px == 90  && ly == 1)  check("cursor_90_1",  {8'h0, outCol()}, 32'h123456);
                    if (px == 100 && ly == 15) check("seg_a_100_15", {8'h0, outCol()}, 32'h000000);
                    if (px == 169 && ly == 21) check("seg_a_169_21", {8'h0, outCol()}, 32'h000000);
                    if (px == 170 && ly == 21) check("seg_a_170_21", {8'h0, outCol()}, 32'h123456);
                    if (px == 100 && ly == 22) check("seg_a_100_22", {8'h0, outCol()}, 32'h123456);
                end
                if (spot == 2 && ly == 15) begin
                    if (px == 100)
                        check("blink_dig0", {8'h0, outCol()},
                              {8'h0, (((mFrame / 32) % 2) == 1) ? bg : 24'h000000});
                    if (px == 190)
                        check("blink_dig1", {8'h0, outCol()}, 32'h000000);
                end
            end
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 24'h0, "hsync");
            step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "hblank");
        end
        check("cur_x", 32'(oCUR_X), 32'(mCx));
        check("cur_y", 32'(oCUR_Y), 32'(mCy));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rgb"},  {8'h0, outCol()}, 32'h0);
        check({tag, "_sync"}, {29'h0, oBLANK_n, oHS, oVS}, 32'b011);
        check({tag, "_curx"}, 32'(oCUR_X), 32'd40);
        check({tag, "_cury"}, 32'(oCUR_Y), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] bg;
        iRST_n = 1'b0; iBLANK_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBGR = '0;
        iSEG = '1; iBLINK = '0;
        pL = 0; pR = 0; pU = 0; pD = 0; setButtons();
        mCx = 40; mCy = 1; mFrame = 0; mAligned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por");
        iRST_n = 1'b1;

        // Background, cursor and digit-0 segment a
        iSEG = {21'h1FFFFF, 7'b1111110};
        frame(24, 200, 1'b0, 1);

        // Random segment patterns over all of digit 0, then the digit row
        iSEG = 28'($urandom);
        frame(157, 172, 1'b1, 0);
        iSEG = 28'($urandom);
        frame(22, 390, 1'b1, 0);

        // Cursor movement and clamping
        pR = 1; setButtons();
        repeat (3) frame(0, 0, 1'b0, 0);
        check("right_3_frames", 32'(oCUR_X), 32'd46);
        pR = 0; pL = 1; setButtons();
        repeat (21) frame(0, 0, 1'b0, 0);
        check("left_to_4", 32'(oCUR_X), 32'd4);
        repeat (5) frame(0, 0, 1'b0, 0);
        check("left_clamp_0", 32'(oCUR_X), 32'd0);
        pL = 0; pU = 1; pD = 1; setButtons();
        repeat (2) frame(0, 0, 1'b0, 0);
        check("up_down_cancel", 32'(oCUR_Y), 32'd1);
        pU = 0; setButtons();
        repeat (215) frame(0, 0, 1'b0, 0);
        check("down_clamp_430", 32'(oCUR_Y), 32'd430);
        repeat (3) frame(0, 0, 1'b0, 0);
        check("down_hold_430", 32'(oCUR_Y), 32'd430);
        pD = 0; pU = 1; setButtons();
        repeat (220) frame(0, 0, 1'b0, 0);
        check("up_clamp_0", 32'(oCUR_Y), 32'd0);
        pU = 0; pR = 1; setButtons();
        repeat (300) frame(0, 0, 1'b0, 0);
        check("right_clamp_590", 32'(oCUR_X), 32'd590);
        pL = 1; setButtons();
        repeat (2) frame(0, 0, 1'b0, 0);
        check("left_right_cancel", 32'(oCUR_X), 32'd590);

        // Random button traffic, with an occasional small pixel frame
        for (int f = 0; f < 60; f++) begin
            {pL, pR, pU, pD} = 4'($urandom);
            setButtons();
            if (f % 10 == 9) begin
                iSEG = 28'($urandom);
                frame(8, 120, 1'b1, 0);
            end else begin
                frame(0, 0, 1'b0, 0);
            end
        end
        pL = 0; pR = 0; pU = 0; pD = 0; setButtons();

        // Reset in the middle of an active line
        repeat (4) step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "idle");
        vsyncModel();
        repeat (2) step(1'b0, 1'b1, 1'b0, 24'($urandom), 24'h0, "vsync");
        repeat (2) step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "bporch");
        for (int px = 0; px < 10; px++) begin
            bg = 24'($urandom);
            step(1'b1, 1'b1, 1'b1, bg, expPix(px, 0, bg), "pre_rst");
        end
        iRST_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        @(posedge clk); @(posedge clk); #1;
        checkResetOutputs("held_rst");
        mCx = 40; mCy = 1; mFrame = 0; mAligned = 1'b0;
        iRST_n = 1'b1;
        for (int ly = 0; ly < 2; ly++) begin
            for (int px = 0; px < 20; px++) begin
                bg = 24'($urandom);
                step(1'b1, 1'b1, 1'b1, bg, expPix(px, ly, bg), "post_rst");
            end
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 24'h0, "hsync");
            step(1'b0, 1'b1, 1'b1, 24'($urandom), 24'h0, "hblank");
        end
        iSEG = {21'h1FFFFF, 7'b1111110};
        frame(24, 200, 1'b0, 1);

`ifdef SEG_BLINK_EN
        iBLINK = 4'b0001;
        iSEG = '0;
        while (mFrame % 64 != 30)
            frame(0, 0, 1'b0, 0);
        frame(16, 200, 1'b1, 2);
        frame(16, 200, 1'b1, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_seg_overlay.md
Name: vga_seg_overlay

Overview:
- Pixel-pipeline overlay stage between video_sync_generator / palette lookup and the VGA DAC outputs.
- Renders NUM_DIGITS parametrised seven-segment digits and one button-driven square cursor over the background pixel stream.
- Tracks pixel position with x/y counters rather than address divide/modulo.
- Cursor moves once per frame, is clamped at the screen edges and has synchronised button inputs.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- NUM_DIGITS, 4, number of digits rendered
- DIG_X0, 100, x of digit 0 origin (top-left)
- DIG_Y0, 15, y of digit origin (all digits share one row)
- DIG_PITCH, 90, x distance between consecutive digit origins; digit i origin = DIG_X0 + i*DIG_PITCH
- SEG_L, 60, segment length in px
- SEG_S, 6, segment thickness in px
- SEG_G, 3, gap between segments in px
- SEG_BGR, 24'h000000, segment colour
- CUR_SIZE, 50, cursor edge length in px
- CUR_X0, 40, cursor reset x
- CUR_Y0, 1, cursor reset y
- CUR_STEP, 2, px moved per frame per pressed direction
- CUR_BGR, 24'h00FF00, cursor colour

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  reset, asynchronous, active-low
- iBLANK_n  in  1  active-video flag from sync generator
- iHS  in  1  hsync, active-low
- iVS  in  1  vsync, active-low
- iBGR  in  24  background pixel, aligned with iBLANK_n; [23:16] B, [15:8] G, [7:0] R
- iSEG  in  7*NUM_DIGITS  segment enables, active-low; digit i = iSEG[7i+6:7i], bit 0..6 = a..g
- mLeft, mRight, mUp, mDown  in  1 each  buttons, active-low, asynchronous
- oBLANK_n, oHS, oVS  out  1 each  syncs delayed to match pixel data
- b_data, g_data, r_data  out  8 each  output colour
- oCUR_X  out  10  current cursor x
- oCUR_Y  out  9  current cursor y

Behaviour:
- Reset: all outputs 0 except oHS=1, oVS=1, oCUR_X=CUR_X0, oCUR_Y=CUR_Y0. Counters 0. Button synchronisers reset to 1 (released).
- Position counters x (10b) and y (9b):
  - x increments every cycle with iBLANK_n=1; x clears on the cycle after iBLANK_n falls.
  - y increments on each iBLANK_n falling edge.
  - x and y both clear while iVS=0.
- Pixel latency is exactly 1 cycle: iBGR/x/y registered to b/g/r, with iBLANK_n/iHS/iVS delayed the same single register stage.
- Priority: cursor > digit segment > iBGR. While iBLANK_n=0, output colour = 0.
- Cursor hit: cx <= x <= cx+CUR_SIZE-1 and cy <= y <= cy+CUR_SIZE-1.
- Segment hit geometry, inclusive, relative to digit origin (dx, dy), with T = SEG_S+SEG_G:
  - a: dy 0..S, dx 0..L+G+S
  - b: dy T..T+L, dx L+G..L+G+S
  - c: dy T+G+L..T+G+2L, dx L+G..L+G+S
  - d: dy T+2G+2L..2S+3G+2L, dx 0..L+G+S
  - e: dy as c, dx 0..S
  - f: dy as b, dx 0..S
  - g: dy T+L..T+L+S, dx T..L
  - A segment is drawn only when its iSEG bit = 0. Overlapping digits: lowest index wins (same colour, so invisible).
- Buttons: 2-flop synchroniser each. Sampled once per frame on the first cycle of iVS low (edge-detected register), so the cursor moves only during vertical blank.
- Cursor update:
  - Left/right both pressed: no x change. Up/down both pressed: no y change.
  - Arithmetic is 11b signed; result is clamped to [0, H_ACT-CUR_SIZE] and [0, V_ACT-CUR_SIZE]. No wrap-around.
- Reset mid-frame: counters restart at 0 and outputs go dark until the next iVS low realigns y.

Optional Feature:
- Macro SEG_BLINK_EN.
- Defined:
  - Adds an 8b frame counter (increments at each vsync edge) and input iBLINK [NUM_DIGITS-1:0].
  - Digit i is suppressed while iBLINK[i]=1 and frame_cnt[5]=1, i.e. 32 frames on, 32 off.
  - Frame counter resets to 0.
- Undefined: port and counter absent; digits are always drawn per iSEG.

Decomposition:
- Package vga_overlay_pkg holds the segment index constants SEG_A..SEG_G, BGR field slice constants, and a function computing segment hit from (dx, dy, L, S, G).
- One sub-module seg_digit_hit: combinational hit test for one digit, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, then release with iSEG all 1 and iBGR=24'h123456: outputs equal 24'h123456 during active video, 1 cycle late; oCUR_X=40, oCUR_Y=1.
- Cursor region: pixel (40,1) = 00FF00; pixel (90,1) = background.
- iSEG digit0 = 7'b1111110 (only a on): pixels (100,15) and (169,21) = 000000; (170,21) and (100,22) = background.
- mRight held low for 3 frames: oCUR_X = 46. mLeft held from x=4 for 5 frames: x = 0, clamped.
- mUp and mDown held together for 2 frames: oCUR_Y unchanged. mDown held from y=428: y stays 430 (480-50).
- SEG_BLINK_EN with iBLINK[0]=1: digit 0 visible frames 0-31, absent frames 32-63, other digits always visible.
